// File: rtl/sha_msg_loader.sv
// sha_msg_loader: packs a 32-bit big-endian word stream into 512-bit message
// blocks for the SHA-256 core, presenting each with the latched bit length.
// Bits past the message length are forced to zero; padding is left to the core.
//
// Build option: define SHA_LOADER_DBLBUF_EN to add a second block buffer so the
// next block fills while the current one is presented (zero-bubble streaming).
//
// Handshakes (valid/ready): a word moves on a rising edge where s_valid and
// s_ready are both 1; a block moves on a rising edge where blk_valid and
// blk_ready are both 1. Neither ready depends combinationally on its valid,
// and blk_data/blk_len/blk_last stay constant while blk_valid is 1.
module sha_msg_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len_in,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [511:0]      blk_data,
  output logic [LEN_W-1:0]  blk_len,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  localparam int BLK_W = 512;
  localparam int NSLOT = BLK_W / WORD_W;
  localparam int SH_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q;
  logic [3:0]        slot;
  logic [LEN_W-1:0]  rem_q, len_q, rem_after;
  logic              last_q, done_q;
  logic              xfer, close_now, close_last, swap;
  logic [WORD_W-1:0] word_masked;

`ifdef SHA_LOADER_DBLBUF_EN
  // sel_q names the buffer being filled; the other one is the presented block.
  logic [1:0][NSLOT-1:0][WORD_W-1:0] buf_q;
  logic                              sel_q;
  logic                              alt_full_q;
  logic                              alt_last_q;
`else
  logic [NSLOT-1:0][WORD_W-1:0]      buf_q;
`endif

  // Slot 0 lands in the top word of the packed block, so index from the top.
  assign slot       = 4'(NSLOT - 1) - wcnt_q;
  assign xfer       = s_valid & s_ready;
  assign close_last = (rem_after == '0);
  assign close_now  = xfer & ((wcnt_q == 4'(NSLOT - 1)) | close_last);

  // Clear bits of the incoming word that lie past the message end; saturating remainder.
  always_comb begin
    word_masked = s_data;
    rem_after   = '0;
    if (rem_q < LEN_W'(WORD_W)) begin
      word_masked = s_data & ~({WORD_W{1'b1}} >> rem_q[SH_W-1:0]);
    end
    if (rem_q > LEN_W'(WORD_W)) begin
      rem_after = rem_q - LEN_W'(WORD_W);
    end
  end

`ifdef SHA_LOADER_DBLBUF_EN
  // Accepting while the alternate block is closed (or closing now) presents it next.
  assign swap     = blk_ready & (alt_full_q | close_now);
  assign blk_data = buf_q[~sel_q];
`else
  assign swap     = 1'b0;
  assign blk_data = buf_q;
`endif

  assign blk_len     = len_q;
  assign blk_last    = last_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (msg_len_in == '0) ? ST_PRESENT : ST_FILL;
      end
      ST_FILL: begin
        if (close_now) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (blk_ready) begin
          if (swap)        state_d = ST_PRESENT;
          else if (last_q) state_d = ST_IDLE;
          else             state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    s_ready   = 1'b0;
    blk_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_FILL: s_ready = 1'b1;
      ST_PRESENT: begin
        blk_valid = 1'b1;
`ifdef SHA_LOADER_DBLBUF_EN
        // Keep filling the alternate buffer while message bits remain and it is open.
        s_ready = (rem_q != '0) & ~alt_full_q;
`endif
      end
      default: busy = 1'b0;
    endcase
  end

`ifdef SHA_LOADER_DBLBUF_EN
  // Datapath: fill buffer sel_q, present buffer ~sel_q, swap on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= '0;
      sel_q      <= 1'b0;
      alt_full_q <= 1'b0;
      alt_last_q <= 1'b0;
      wcnt_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q      <= msg_len_in;
            rem_q      <= msg_len_in;
            buf_q      <= '0;
            wcnt_q     <= '0;
            sel_q      <= 1'b0;
            alt_full_q <= 1'b0;
            alt_last_q <= 1'b0;
            last_q     <= (msg_len_in == '0);
          end
        end
        ST_FILL: begin
          if (xfer) begin
            buf_q[sel_q][slot] <= word_masked;
            rem_q              <= rem_after;
            wcnt_q             <= close_now ? 4'd0 : wcnt_q + 4'd1;
            if (close_now) begin
              last_q <= close_last;
              sel_q  <= ~sel_q;
            end
          end
        end
        ST_PRESENT: begin
          if (xfer) begin
            buf_q[sel_q][slot] <= word_masked;
            rem_q              <= rem_after;
            wcnt_q             <= close_now ? 4'd0 : wcnt_q + 4'd1;
          end
          if (blk_ready) begin
            buf_q[~sel_q] <= '0;
            if (swap) begin
              sel_q      <= ~sel_q;
              last_q     <= alt_full_q ? alt_last_q : close_last;
              alt_full_q <= 1'b0;
            end else if (last_q) begin
              last_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else if (close_now) begin
            alt_full_q <= 1'b1;
            alt_last_q <= close_last;
          end
        end
        default: ;
      endcase
    end
  end
`else
  // Datapath: single buffer, filled in FILL and held in PRESENT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      wcnt_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q  <= msg_len_in;
            rem_q  <= msg_len_in;
            buf_q  <= '0;
            wcnt_q <= '0;
            last_q <= (msg_len_in == '0);
          end
        end
        ST_FILL: begin
          if (xfer) begin
            buf_q[slot] <= word_masked;
            rem_q       <= rem_after;
            wcnt_q      <= close_now ? 4'd0 : wcnt_q + 4'd1;
            if (close_now) last_q <= close_last;
          end
        end
        ST_PRESENT: begin
          if (blk_ready) begin
            buf_q  <= '0;
            wcnt_q <= '0;
            if (last_q) begin
              last_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
